pc_fetch_sequencer: RTL and testbench

//  Control FSM for the TMP8 8-bit program counter (load/enable/clear counter).

---
 rtl/pc_fetch_sequencer.sv | 165 ++++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// Control sequencer for the TMP8 program counter: boot load, fetch handshake, increment, branch.
// Optional interrupt entry is compiled in when PC_SEQ_IRQ_EN is defined.
module pc_fetch_sequencer #(
  parameter logic [7:0]  RESET_VECTOR = 8'h00,
  parameter logic [7:0]  HALT_OPCODE  = 8'hFF,
  parameter int unsigned WAIT_LIMIT   = 15,
  parameter logic [7:0]  IRQ_VECTOR   = 8'hF0
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       run,
  input  logic       soft_rst,
  input  logic       mem_ack,
  input  logic [7:0] mem_data,
  input  logic       exec_done,
  input  logic       branch_req,
  input  logic [7:0] branch_target,
  input  logic [7:0] pc_value,
`ifdef PC_SEQ_IRQ_EN
  input  logic       irq,
  input  logic       irq_ret,
  output logic       irq_ack,
  output logic [7:0] epc,
`endif
  output logic       mem_req,
  output logic [7:0] ir,
  output logic       exec_start,
  output logic       pc_clear,
  output logic       pc_load,
  output logic       pc_enable,
  output logic [7:0] pc_load_data,
  output logic       halted,
  output logic       bus_err
);

  localparam logic [7:0] WaitLim = 8'(WAIT_LIMIT);

  typedef enum logic [2:0] {StBoot, StIdle, StFetch, StExec, StHalt} state_e;

  state_e     state;
  logic [7:0] wait_cnt;

`ifdef PC_SEQ_IRQ_EN
  logic in_isr;
`else
  logic unused_pc_value;
  assign unused_pc_value = ^pc_value;
`endif

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state        <= StBoot;
      wait_cnt     <= 8'd0;
      mem_req      <= 1'b0;
      ir           <= 8'h00;
      exec_start   <= 1'b0;
      pc_clear     <= 1'b0;
      pc_load      <= 1'b0;
      pc_enable    <= 1'b0;
      pc_load_data <= RESET_VECTOR;
      halted       <= 1'b0;
      bus_err      <= 1'b0;
`ifdef PC_SEQ_IRQ_EN
      irq_ack      <= 1'b0;
      epc          <= 8'h00;
      in_isr       <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle; only the branches below raise them.
      exec_start <= 1'b0;
      pc_clear   <= 1'b0;
      pc_load    <= 1'b0;
      pc_enable  <= 1'b0;
`ifdef PC_SEQ_IRQ_EN
      irq_ack    <= 1'b0;
`endif
      if (soft_rst) begin
        pc_clear <= 1'b1;
        mem_req  <= 1'b0;
        bus_err  <= 1'b0;
        halted   <= 1'b0;
        wait_cnt <= 8'd0;
        state    <= StBoot;
`ifdef PC_SEQ_IRQ_EN
        epc      <= 8'h00;
        in_isr   <= 1'b0;
`endif
      end else begin
`ifdef PC_SEQ_IRQ_EN
        if (irq_ret) in_isr <= 1'b0;
`endif
        unique case (state)
          StBoot: begin
            pc_load      <= 1'b1;
            pc_load_data <= RESET_VECTOR;
            state        <= StIdle;
          end
          StIdle: begin
            if (run) begin
              mem_req  <= 1'b1;
              wait_cnt <= 8'd0;
              state    <= StFetch;
            end
          end
          StFetch: begin
            if (mem_ack) begin
              ir      <= mem_data;
              mem_req <= 1'b0;
              if (mem_data == HALT_OPCODE) begin
                halted <= 1'b1;
                state  <= StHalt;
              end else begin
                pc_enable  <= 1'b1;
                exec_start <= 1'b1;
                state      <= StExec;
              end
            end else if (wait_cnt + 8'd1 == WaitLim) begin
              bus_err <= 1'b1;
              mem_req <= 1'b0;
              halted  <= 1'b1;
              state   <= StHalt;
            end else begin
              wait_cnt <= wait_cnt + 8'd1;
            end
          end
          StExec: begin
            // Load cycles return through IDLE so the next fetch never overlaps them.
            if (exec_done) begin
              if (branch_req) begin
                pc_load      <= 1'b1;
                pc_load_data <= branch_target;
                state        <= StIdle;
              end
`ifdef PC_SEQ_IRQ_EN
              else if (irq && !in_isr) begin
                epc          <= pc_value;
                pc_load      <= 1'b1;
                pc_load_data <= IRQ_VECTOR;
                irq_ack      <= 1'b1;
                in_isr       <= 1'b1;
                state        <= StIdle;
              end
`endif
              else if (run) begin
                mem_req  <= 1'b1;
                wait_cnt <= 8'd0;
                state    <= StFetch;
              end else begin
                state <= StIdle;
              end
            end
          end
          StHalt: begin
            if (!run) begin
              halted <= 1'b0;
              state  <= StIdle;
            end
          end
          default: state <= StBoot;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed scenario with literal expectations, then random stimulus
// checked every cycle against a behavioural model; a simple PC counter closes the loop.
module tb_pc_fetch_sequencer;

  logic       clk = 1'b0;
  logic       clear_n;
  logic       run, soft_rst, mem_ack, exec_done, branch_req;
  logic [7:0] mem_data, branch_target, pc_value;
  logic       mem_req, exec_start, pc_clear, pc_load, pc_enable, halted, bus_err;
  logic [7:0] ir, pc_load_data;
`ifdef PC_SEQ_IRQ_EN
  logic       irq, irq_ret, irq_ack;
  logic [7:0] epc;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_fetch_sequencer dut (
    .clk           (clk),
    .clear_n       (clear_n),
    .run           (run),
    .soft_rst      (soft_rst),
    .mem_ack       (mem_ack),
    .mem_data      (mem_data),
    .exec_done     (exec_done),
    .branch_req    (branch_req),
    .branch_target (branch_target),
    .pc_value      (pc_value),
`ifdef PC_SEQ_IRQ_EN
    .irq           (irq),
    .irq_ret       (irq_ret),
    .irq_ack       (irq_ack),
    .epc           (epc),
`endif
    .mem_req       (mem_req),
    .ir            (ir),
    .exec_start    (exec_start),
    .pc_clear      (pc_clear),
    .pc_load       (pc_load),
    .pc_enable     (pc_enable),
    .pc_load_data  (pc_load_data),
    .halted        (halted),
    .bus_err       (bus_err)
  );

  // Program counter driven by the sequencer's strobes.
  initial pc_value = 8'h00;
  always @(posedge clk) begin
    if (pc_clear)       pc_value <= 8'h00;
    else if (pc_load)   pc_value <= pc_load_data;
    else if (pc_enable) pc_value <= pc_value + 8'd1;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: where the sequencer is and what happened on the last edge.
  localparam int P_BOOT = 0, P_IDLE = 1, P_FETCH = 2, P_EXEC = 3, P_HALT = 4;
  localparam int E_NONE = 0, E_BOOT = 1, E_FETCHED = 2, E_BRANCH = 3, E_SOFT = 4, E_IRQ = 5;

  int         m_phase, m_ev, m_waits;
  logic [7:0] m_ir, m_load;
  logic       m_berr;
  logic [7:0] m_epc;
  logic       m_isr;

  always @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      m_phase = P_BOOT; m_ev = E_NONE; m_waits = 0;
      m_ir = 8'h00; m_load = 8'h00; m_berr = 1'b0; m_epc = 8'h00; m_isr = 1'b0;
    end else begin
      m_ev = E_NONE;
      if (soft_rst) begin
        m_ev = E_SOFT; m_phase = P_BOOT; m_berr = 1'b0; m_epc = 8'h00; m_isr = 1'b0;
      end else begin
`ifdef PC_SEQ_IRQ_EN
        if (irq_ret) m_isr = 1'b0;
`endif
        if (m_phase == P_BOOT) begin
          m_ev = E_BOOT; m_load = 8'h00; m_phase = P_IDLE;
        end else if (m_phase == P_IDLE) begin
          if (run) begin m_phase = P_FETCH; m_waits = 0; end
        end else if (m_phase == P_FETCH) begin
          if (mem_ack) begin
            m_ir = mem_data;
            if (mem_data == 8'hFF) m_phase = P_HALT;
            else begin m_ev = E_FETCHED; m_phase = P_EXEC; end
          end else begin
            m_waits++;
            if (m_waits == 15) begin m_berr = 1'b1; m_phase = P_HALT; end
          end
        end else if (m_phase == P_EXEC) begin
          if (exec_done) begin
            if (branch_req) begin
              m_ev = E_BRANCH; m_load = branch_target; m_phase = P_IDLE;
`ifdef PC_SEQ_IRQ_EN
            end else if (irq && !m_isr) begin
              m_ev = E_IRQ; m_load = 8'hF0; m_epc = pc_value; m_isr = 1'b1; m_phase = P_IDLE;
`endif
            end else begin
              m_phase = run ? P_FETCH : P_IDLE;
              m_waits = 0;
            end
          end
        end else if (!run) begin
          m_phase = P_IDLE;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("mem_req",      {7'd0, mem_req},    {7'd0, m_phase == P_FETCH});
    check("halted",       {7'd0, halted},     {7'd0, m_phase == P_HALT});
    check("pc_load",      {7'd0, pc_load},
          {7'd0, m_ev == E_BOOT || m_ev == E_BRANCH || m_ev == E_IRQ});
    check("pc_enable",    {7'd0, pc_enable},  {7'd0, m_ev == E_FETCHED});
    check("exec_start",   {7'd0, exec_start}, {7'd0, m_ev == E_FETCHED});
    check("pc_clear",     {7'd0, pc_clear},   {7'd0, m_ev == E_SOFT});
    check("pc_load_data", pc_load_data, m_load);
    check("ir",           ir, m_ir);
    check("bus_err",      {7'd0, bus_err},    {7'd0, m_berr});
`ifdef PC_SEQ_IRQ_EN
    check("irq_ack",      {7'd0, irq_ack},    {7'd0, m_ev == E_IRQ});
    check("epc",          epc, m_epc);
`endif
  end

  initial begin
    clear_n = 1'b0; run = 1'b0; soft_rst = 1'b0; mem_ack = 1'b0; mem_data = 8'h00;
    exec_done = 1'b0; branch_req = 1'b0; branch_target = 8'h00;
`ifdef PC_SEQ_IRQ_EN
    irq = 1'b0; irq_ret = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_mem_req", {7'd0, mem_req}, 8'h00);
    check("rst_pc_load", {7'd0, pc_load}, 8'h00);
    check("rst_ir", ir, 8'h00);
    check("rst_load_data", pc_load_data, 8'h00);
    clear_n = 1'b1; run = 1'b1;

    @(negedge clk);
    check("boot_pc_load", {7'd0, pc_load}, 8'h01);
    check("boot_load_data", pc_load_data, 8'h00);
    @(negedge clk);
    check("first_mem_req", {7'd0, mem_req}, 8'h01);
    repeat (2) @(negedge clk);
    mem_ack = 1'b1; mem_data = 8'h3A;
    @(negedge clk);
    check("fetch_ir", ir, 8'h3A);
    check("fetch_pc_enable", {7'd0, pc_enable}, 8'h01);
    check("fetch_exec_start", {7'd0, exec_start}, 8'h01);
    mem_ack = 1'b0; exec_done = 1'b1; branch_req = 1'b1; branch_target = 8'h80;
    @(negedge clk);
    check("branch_pc_load", {7'd0, pc_load}, 8'h01);
    check("branch_data", pc_load_data, 8'h80);
    check("branch_no_enable", {7'd0, pc_enable}, 8'h00);
    check("branch_no_req", {7'd0, mem_req}, 8'h00);
    exec_done = 1'b0; branch_req = 1'b0;
    @(negedge clk);
    check("branch_mem_req", {7'd0, mem_req}, 8'h01);
    check("branch_pc", pc_value, 8'h80);
    mem_ack = 1'b1; mem_data = 8'hFF;
    @(negedge clk);
    check("halt_halted", {7'd0, halted}, 8'h01);
    check("halt_no_enable", {7'd0, pc_enable}, 8'h00);
    mem_ack = 1'b0; run = 1'b0;
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    check("refetch_mem_req", {7'd0, mem_req}, 8'h01);
    check("refetch_same_pc", pc_value, 8'h80);
    repeat (14) @(negedge clk);
    check("timeout_pending", {7'd0, bus_err}, 8'h00);
    @(negedge clk);
    check("timeout_bus_err", {7'd0, bus_err}, 8'h01);
    check("timeout_mem_req", {7'd0, mem_req}, 8'h00);
    check("timeout_halted", {7'd0, halted}, 8'h01);
    soft_rst = 1'b1;
    @(negedge clk);
    check("soft_pc_clear", {7'd0, pc_clear}, 8'h01);
    check("soft_bus_err", {7'd0, bus_err}, 8'h00);
    soft_rst = 1'b0;
    @(negedge clk);
    check("soft_boot_load", {7'd0, pc_load}, 8'h01);
    check("soft_pc_zero", pc_value, 8'h00);

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      run           = ($urandom_range(0, 99) < 85);
      soft_rst      = ($urandom_range(0, 199) == 0);
      mem_ack       = mem_req ? ($urandom_range(0, 99) < 25) : ($urandom_range(0, 99) < 5);
      mem_data      = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom);
      exec_done     = ($urandom_range(0, 99) < 30);
      branch_req    = ($urandom_range(0, 2) == 0);
      branch_target = 8'($urandom);
`ifdef PC_SEQ_IRQ_EN
      irq           = ($urandom_range(0, 3) == 0);
      irq_ret       = ($urandom_range(0, 29) == 0);
`endif
      if (mem_req && $urandom_range(0, 149) == 0) begin
        #2 clear_n = 1'b0;
        #1 check("async_mem_req_drop", {7'd0, mem_req}, 8'h00);
        @(negedge clk);
        clear_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
